// File: rtl/commit_unit_pkg.sv
// Shared types for the commit stage: instruction classes, FSM state encoding
// and the ROB head entry layout seen at the ROB read end.
package commit_unit_pkg;

   localparam int ROB_XLEN  = 32;
   localparam int ROB_TAG_W = 4;

   localparam logic [1:0] ITYPE_BRANCH = 2'b00;
   localparam logic [1:0] ITYPE_ALU    = 2'b01;
   localparam logic [1:0] ITYPE_STORE  = 2'b10;
   localparam logic [1:0] ITYPE_LOAD   = 2'b11;

   typedef enum logic [1:0] {
      S_COMMIT = 2'd0,
      S_STORE  = 2'd1,
      S_FLUSH  = 2'd2
   } commit_state_t;

   typedef struct packed {
      logic [1:0]           itype;
      logic [ROB_TAG_W-1:0] ROB_number;
      logic [4:0]           dest;
      logic [ROB_XLEN-1:0]  value;
      logic [ROB_XLEN-1:0]  st_addr;
      logic                 branch_result;
      logic [ROB_XLEN-1:0]  target;
   } ROB_entry_t;

   function automatic logic writes_rf(input logic [1:0] itype);
      return (itype == ITYPE_ALU) || (itype == ITYPE_LOAD);
   endfunction

endpackage

// File: rtl/commit_perf_counters.sv
// Retire and flush event counters for the commit stage; both wrap at their
// maximum and clear on reset. Only built when COMMIT_PERF_EN is defined.
module commit_perf_counters (
   input  logic        clk,
   input  logic        reset,
   input  logic        commit_pulse,
   input  logic        flush_pulse,
   output logic [31:0] commit_count,
   output logic [15:0] flush_count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         commit_count <= '0;
         flush_count  <= '0;
      end else begin
         if (commit_pulse) commit_count <= commit_count + 32'd1;
         if (flush_pulse)  flush_count  <= flush_count + 16'd1;
      end
   end

endmodule

// File: rtl/commit_unit.sv
// In-order retirement at the ROB head: RF writes, store handshake, branch flush.
// Optional perf counters are enabled by defining COMMIT_PERF_EN.
module commit_unit
   import commit_unit_pkg::*;
#(
   parameter int XLEN         = ROB_XLEN,
   parameter int ROB_IDX_W    = ROB_TAG_W,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  ROB_entry_t           head,
   input  logic                 head_valid,
   input  logic                 head_ready,
   output logic                 rd_en,
   output logic                 rf_wr_en,
   output logic [4:0]           rf_wr_addr,
   output logic [XLEN-1:0]      rf_wr_data,
   output logic [ROB_IDX_W-1:0] rf_wr_rob,
   output logic                 st_req,
   output logic [XLEN-1:0]      st_addr,
   output logic [XLEN-1:0]      st_data,
   input  logic                 st_ack,
   output logic                 flush,
   output logic [XLEN-1:0]      redirect_pc,
   output logic [31:0]          commit_count,
   output logic [15:0]          flush_count
);

   localparam logic [1:0] ST_COMMIT = S_COMMIT;
   localparam logic [1:0] ST_STORE  = S_STORE;
   localparam logic [1:0] ST_FLUSH  = S_FLUSH;

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   logic [1:0]      state, next_state;
   logic [CNT_W-1:0] flush_cnt;
   logic [XLEN-1:0] st_addr_q, st_data_q, target_q;
   logic            commit_c, store_take, flush_entry;

   assign commit_c = head_valid & head_ready;

   // Every output is forced low while reset is asserted, whatever the head shows.
   always_comb begin
      rd_en       = 1'b0;
      rf_wr_en    = 1'b0;
      rf_wr_addr  = '0;
      rf_wr_data  = '0;
      rf_wr_rob   = '0;
      st_req      = 1'b0;
      st_addr     = '0;
      st_data     = '0;
      flush       = 1'b0;
      redirect_pc = '0;
      next_state  = state;
      store_take  = 1'b0;
      flush_entry = 1'b0;
      if (!reset) begin
         case (state)
            ST_COMMIT: begin
               if (commit_c) begin
                  if (writes_rf(head.itype)) begin
                     rd_en      = 1'b1;
                     rf_wr_en   = (head.dest != 5'd0);
                     rf_wr_addr = head.dest;
                     rf_wr_data = XLEN'(head.value);
                     rf_wr_rob  = ROB_IDX_W'(head.ROB_number);
                  end else if (head.itype == ITYPE_STORE) begin
                     store_take = 1'b1;
                     next_state = ST_STORE;
                  end else begin
                     rd_en = 1'b1;
                     if (head.branch_result) begin
                        flush_entry = 1'b1;
                        next_state  = ST_FLUSH;
                     end
                  end
               end
            end
            ST_STORE: begin
               st_req  = 1'b1;
               st_addr = st_addr_q;
               st_data = st_data_q;
               if (st_ack) begin
                  rd_en      = 1'b1;
                  next_state = ST_COMMIT;
               end
            end
            ST_FLUSH: begin
               flush       = 1'b1;
               redirect_pc = target_q;
               if (flush_cnt == '0) next_state = ST_COMMIT;
            end
            default: next_state = ST_COMMIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_COMMIT;
         flush_cnt <= '0;
      end else begin
         state <= next_state;
         if (flush_entry)
            flush_cnt <= CNT_LOAD;
         else if (state == ST_FLUSH && flush_cnt != '0)
            flush_cnt <= flush_cnt - 1'b1;
      end
   end

   // Store and redirect payloads are captured at commit and held for the handshake.
   always_ff @(posedge clk) begin
      if (store_take) begin
         st_addr_q <= XLEN'(head.st_addr);
         st_data_q <= XLEN'(head.value);
      end
      if (flush_entry) target_q <= XLEN'(head.target);
   end

`ifdef COMMIT_PERF_EN
   commit_perf_counters u_perf (
      .clk          (clk),
      .reset        (reset),
      .commit_pulse (rd_en),
      .flush_pulse  (flush_entry),
      .commit_count (commit_count),
      .flush_count  (flush_count)
   );
`else
   assign commit_count = 32'd0;
   assign flush_count  = 16'd0;
`endif

endmodule
